sme_share_store: RTL and testbench

- Parametrised successor share-storage block for the SME unit.
- Holds shares 1..SMAX-1 of every masked register; share 0 stays in the RISC-V GPRs.
- Adds a bank-transfer sequencer that streams all live shares out to memory (save) or in from memory (restore) for context switch, over valid/ready handshakes.
- Sits between the SME ALU/crypto result path and the LSU.

---
 rtl/sme_share_store.sv | 216 +++++++++++++++++++++
 tb/tb_sme_share_store.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_share_store.sv
// Share storage for shares 1..SMAX-1 of each masked register, with a save/restore bank-transfer sequencer.
// Optional share refresh in IDLE is enabled by defining SME_SHARE_REFRESH_EN.
module sme_share_store #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SMAX  = 4,
  parameter int unsigned NREGS = 16,
  localparam int unsigned RA   = $clog2(NREGS),
  localparam int unsigned SW   = (SMAX - 1) * XLEN
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  output logic            g_clk_req,
  input  logic            flush,
  input  logic [3:0]      smectl_d,
`ifdef SME_SHARE_REFRESH_EN
  input  logic [XLEN-1:0] rng,
  input  logic            smectl_t,
`endif
  input  logic [RA-1:0]   rs1_addr,
  output logic [SW-1:0]   rs1_rdata,
  input  logic [RA-1:0]   rs2_addr,
  output logic [SW-1:0]   rs2_rdata,
  input  logic            rd_wen,
  input  logic [RA-1:0]   rd_addr,
  input  logic [SW-1:0]   rd_wdata,
  input  logic            xfer_start,
  input  logic            xfer_dir,
  output logic            xfer_busy,
  output logic            xfer_done,
  output logic            so_valid,
  input  logic            so_ready,
  output logic [XLEN-1:0] so_data,
  output logic [RA-1:0]   so_reg,
  output logic [3:0]      so_share,
  input  logic            si_valid,
  output logic            si_ready,
  input  logic [XLEN-1:0] si_data
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SAVE    = 2'd1;
  localparam logic [1:0] ST_RESTORE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [3:0]    SMAX_L   = 4'(SMAX);
  localparam logic [RA-1:0] REG_LAST = RA'(NREGS - 1);

  logic [SW-1:0]   mem_q [NREGS];
  logic [SW-1:0]   mem_d [NREGS];

  logic [1:0]      state_q, state_d;
  logic [RA-1:0]   reg_ptr_q, reg_ptr_d;
  logic [3:0]      sh_ptr_q, sh_ptr_d;
  logic [3:0]      d_q, d_d;

  logic            xfer_busy_q, xfer_busy_d;
  logic            xfer_done_q, xfer_done_d;
  logic            so_valid_q, so_valid_d;
  logic            si_ready_q, si_ready_d;
  logic [XLEN-1:0] so_data_q, so_data_d;
  logic [RA-1:0]   so_reg_q, so_reg_d;
  logic [3:0]      so_share_q, so_share_d;

  logic [3:0]      d_clamp_c;
  logic [3:0]      sh_last_c;
  logic            save_beat_c;
  logic            rest_beat_c;
  logic            last_beat_c;

  // Select share k (1-based) out of a packed share vector.
  function automatic logic [XLEN-1:0] share_of(input logic [SW-1:0] v, input logic [3:0] k);
    share_of = '0;
    for (int i = 1; i < int'(SMAX); i++) begin
      if (k == 4'(i)) share_of = v[(i-1)*XLEN +: XLEN];
    end
  endfunction

  assign d_clamp_c   = (smectl_d > SMAX_L) ? SMAX_L : smectl_d;
  assign sh_last_c   = d_q - 4'd1;
  assign save_beat_c = (state_q == ST_SAVE) && so_valid_q && so_ready;
  assign rest_beat_c = (state_q == ST_RESTORE) && si_ready_q && si_valid;
  assign last_beat_c = (reg_ptr_q == REG_LAST) && (sh_ptr_q == sh_last_c);

  assign rs1_rdata = mem_q[rs1_addr];
  assign rs2_rdata = mem_q[rs2_addr];

  assign g_clk_req = xfer_busy_q | rd_wen;
  assign xfer_busy = xfer_busy_q;
  assign xfer_done = xfer_done_q;
  assign so_valid  = so_valid_q;
  assign si_ready  = si_ready_q;
  assign so_data   = so_data_q;
  assign so_reg    = so_reg_q;
  assign so_share  = so_share_q;

`ifdef SME_SHARE_REFRESH_EN
  localparam int unsigned S2_LO = (SMAX >= 3) ? XLEN : 0;

  logic [RA-1:0] rf_ptr_q, rf_ptr_d;
  logic          refresh_c;

  // Refresh re-randomises shares 1 and 2 together so their XOR is preserved.
  assign refresh_c = (state_q == ST_IDLE) && !rd_wen && !smectl_t && (d_clamp_c >= 4'd3);
  assign rf_ptr_d  = refresh_c ? rf_ptr_q + RA'(1) : rf_ptr_q;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) rf_ptr_q <= '0;
    else           rf_ptr_q <= rf_ptr_d;
  end
`endif

  // Next storage contents: result writes only while idle, restore beats while restoring.
  always_comb begin
    for (int r = 0; r < int'(NREGS); r++) mem_d[r] = mem_q[r];
`ifdef SME_SHARE_REFRESH_EN
    if (refresh_c) begin
      mem_d[rf_ptr_q][XLEN-1:0]      = mem_q[rf_ptr_q][XLEN-1:0] ^ rng;
      mem_d[rf_ptr_q][S2_LO +: XLEN] = mem_q[rf_ptr_q][S2_LO +: XLEN] ^ rng;
    end
`endif
    if (rd_wen && (state_q == ST_IDLE)) mem_d[rd_addr] = rd_wdata;
    if (rest_beat_c) begin
      for (int i = 1; i < int'(SMAX); i++) begin
        if (sh_ptr_q == 4'(i)) mem_d[reg_ptr_q][(i-1)*XLEN +: XLEN] = si_data;
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int r = 0; r < int'(NREGS); r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < int'(NREGS); r++) mem_q[r] <= mem_d[r];
    end
  end

  // Transfer sequencer: next state, pointers and registered stream outputs.
  always_comb begin
    state_d     = state_q;
    reg_ptr_d   = reg_ptr_q;
    sh_ptr_d    = sh_ptr_q;
    d_d         = d_q;
    so_data_d   = so_data_q;
    so_reg_d    = so_reg_q;
    so_share_d  = so_share_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer_start) begin
          d_d       = d_clamp_c;
          reg_ptr_d = '0;
          sh_ptr_d  = 4'd1;
          if (d_clamp_c <= 4'd1) state_d = ST_DONE;
          else if (xfer_dir)     state_d = ST_RESTORE;
          else                   state_d = ST_SAVE;
        end
      end
      ST_SAVE, ST_RESTORE: begin
        if (save_beat_c || rest_beat_c) begin
          if (last_beat_c) begin
            state_d = ST_DONE;
          end else if (sh_ptr_q == sh_last_c) begin
            sh_ptr_d  = 4'd1;
            reg_ptr_d = reg_ptr_q + RA'(1);
          end else begin
            sh_ptr_d  = sh_ptr_q + 4'd1;
          end
        end
        if (flush) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    xfer_busy_d = (state_d != ST_IDLE);
    xfer_done_d = (state_d == ST_DONE);
    so_valid_d  = (state_d == ST_SAVE);
    si_ready_d  = (state_d == ST_RESTORE);

    // A stalled beat keeps its payload; otherwise present the next beat.
    if ((state_d == ST_SAVE) && !(so_valid_q && !so_ready)) begin
      so_data_d  = share_of(mem_d[reg_ptr_d], sh_ptr_d);
      so_reg_d   = reg_ptr_d;
      so_share_d = sh_ptr_d;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q     <= ST_IDLE;
      reg_ptr_q   <= '0;
      sh_ptr_q    <= '0;
      d_q         <= '0;
      xfer_busy_q <= 1'b0;
      xfer_done_q <= 1'b0;
      so_valid_q  <= 1'b0;
      si_ready_q  <= 1'b0;
      so_data_q   <= '0;
      so_reg_q    <= '0;
      so_share_q  <= '0;
    end else begin
      state_q     <= state_d;
      reg_ptr_q   <= reg_ptr_d;
      sh_ptr_q    <= sh_ptr_d;
      d_q         <= d_d;
      xfer_busy_q <= xfer_busy_d;
      xfer_done_q <= xfer_done_d;
      so_valid_q  <= so_valid_d;
      si_ready_q  <= si_ready_d;
      so_data_q   <= so_data_d;
      so_reg_q    <= so_reg_d;
      so_share_q  <= so_share_d;
    end
  end

endmodule

// File: tb/tb_sme_share_store.sv
// Scoreboard bench for sme_share_store: reads/writes, save and restore streams, flush, reset and clamping.
module tb_sme_share_store;

  localparam int XLEN  = 32;
  localparam int SMAX  = 4;
  localparam int NREGS = 16;
  localparam int RA    = 4;
  localparam int SW    = (SMAX - 1) * XLEN;

  logic            g_clk = 1'b0;
  logic            g_resetn;
  logic            g_clk_req;
  logic            flush;
  logic [3:0]      smectl_d;
  logic [RA-1:0]   rs1_addr, rs2_addr, rd_addr;
  logic [SW-1:0]   rs1_rdata, rs2_rdata, rd_wdata;
  logic            rd_wen;
  logic            xfer_start, xfer_dir, xfer_busy, xfer_done;
  logic            so_valid, so_ready;
  logic [XLEN-1:0] so_data;
  logic [RA-1:0]   so_reg;
  logic [3:0]      so_share;
  logic            si_valid, si_ready;
  logic [XLEN-1:0] si_data;
`ifdef SME_SHARE_REFRESH_EN
  logic [XLEN-1:0] rng;
  logic            smectl_t;
`endif

  sme_share_store dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(g_clk_req), .flush(flush),
    .smectl_d(smectl_d),
`ifdef SME_SHARE_REFRESH_EN
    .rng(rng), .smectl_t(smectl_t),
`endif
    .rs1_addr(rs1_addr), .rs1_rdata(rs1_rdata), .rs2_addr(rs2_addr), .rs2_rdata(rs2_rdata),
    .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .xfer_start(xfer_start), .xfer_dir(xfer_dir), .xfer_busy(xfer_busy), .xfer_done(xfer_done),
    .so_valid(so_valid), .so_ready(so_ready), .so_data(so_data), .so_reg(so_reg), .so_share(so_share),
    .si_valid(si_valid), .si_ready(si_ready), .si_data(si_data)
  );

  always #5 g_clk = ~g_clk;

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0]  model [NREGS][SMAX];
  logic [127:0] sb_q [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Upstream must stall result writes during a transfer.
  always @(negedge g_clk) begin
    if (g_resetn && rd_wen && xfer_busy) begin
      n_bad++;
      $display("FAIL rd_wen_while_busy: got=1 want=0");
    end
  end

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  function automatic logic [SW-1:0] pack_reg(input int r);
    return {model[r][3], model[r][2], model[r][1]};
  endfunction

  function automatic int clamp_d(input int d);
    return (d > SMAX) ? SMAX : d;
  endfunction

  task automatic write_reg(input int r, input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] s3);
    rd_addr  = RA'(r);
    rd_wdata = {s3, s2, s1};
    rd_wen   = 1'b1;
    tick();
    rd_wen   = 1'b0;
    model[r][1] = s1;
    model[r][2] = s2;
    model[r][3] = s3;
  endtask

  task automatic verify_all(input string tag);
    for (int r = 0; r < NREGS; r++) begin
      sb_q.push_back(128'(pack_reg(r)));
      sb_q.push_back(128'(pack_reg(NREGS - 1 - r)));
      rs1_addr = RA'(r);
      rs2_addr = RA'(NREGS - 1 - r);
      #1;
      check({tag, "_rs1"}, 128'(rs1_rdata), sb_q.pop_front());
      check({tag, "_rs2"}, 128'(rs2_rdata), sb_q.pop_front());
    end
  endtask

  task automatic start_xfer(input int dval, input logic dir);
    smectl_d   = 4'(dval);
    xfer_dir   = dir;
    xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
  endtask

  task automatic run_save(input int dval, input int stall_at);
    int deff, beats, stall_n, cyc, last_c;
    logic done, poked, stalled;
    logic [40:0] cur, held;
    deff = clamp_d(dval);
    beats = 0; stall_n = 0; cyc = 0; last_c = -100; done = 1'b0; poked = 1'b0; held = '0;
    for (int r = 0; r < NREGS; r++)
      for (int k = 1; k < deff; k++)
        sb_q.push_back(128'({4'(r), 4'(k), model[r][k]}));
    start_xfer(dval, 1'b0);
    check("save_first_valid", 128'(so_valid), 128'(1));
    while (!done && cyc < 600) begin
      xfer_start = 1'b0;
      if (beats == 3 && !poked) begin
        xfer_start = 1'b1;
        xfer_dir   = 1'b1;
        smectl_d   = 4'd2;
        poked      = 1'b1;
      end
      stalled  = so_valid && (beats == stall_at) && (stall_n < 3);
      so_ready = !stalled;
      cur = {so_valid, so_reg, so_share, so_data};
      if (stalled) begin
        if (stall_n == 0) held = cur;
        else check("save_stall_hold", 128'(cur), 128'(held));
        stall_n++;
      end else if (so_valid) begin
        if (sb_q.size() == 0) check("save_extra_beat", 128'(1), 128'(0));
        else check("save_beat", 128'({so_reg, so_share, so_data}), sb_q.pop_front());
        beats++;
        last_c = cyc;
      end
      if (xfer_done) begin
        done = 1'b1;
        check("save_done_lat", 128'(cyc - last_c), 128'(1));
      end else begin
        tick();
        cyc++;
      end
    end
    xfer_start = 1'b0;
    check("save_done_seen", 128'(done), 128'(1));
    check("save_beats", 128'(beats), 128'(NREGS * (deff - 1)));
    check("save_q_empty", 128'(sb_q.size()), 128'(0));
    sb_q.delete();
    tick();
    check("save_done_pulse", 128'({xfer_done, xfer_busy}), 128'(0));
  endtask

  task automatic run_restore(input int dval, input logic [31:0] base, input int flush_at, input logic flush_commit);
    int deff, i, cyc, last_c;
    logic done, stopped;
    deff = clamp_d(dval);
    i = 0; cyc = 0; last_c = -100; done = 1'b0; stopped = 1'b0;
    start_xfer(dval, 1'b1);
    check("rst_first_ready", 128'(si_ready), 128'(1));
    while (!done && !stopped && cyc < 600) begin
      if (xfer_done) begin
        done = 1'b1;
        check("rst_done_lat", 128'(cyc - last_c), 128'(1));
      end else begin
        si_data = base + 32'(i);
        if (i == flush_at) begin
          flush    = 1'b1;
          si_valid = flush_commit;
        end else begin
          si_valid = (cyc % 7) != 6;
        end
        if (si_valid && si_ready) begin
          model[i / (deff - 1)][i % (deff - 1) + 1] = base + 32'(i);
          i++;
          last_c = cyc;
        end
        tick();
        cyc++;
        if (flush) begin
          stopped = 1'b1;
          flush   = 1'b0;
          si_valid = 1'b0;
          check("rst_flush_idle", 128'({xfer_busy, si_ready, xfer_done}), 128'(0));
          tick();
          check("rst_flush_no_done", 128'({xfer_busy, xfer_done}), 128'(0));
        end
        si_valid = 1'b0;
      end
    end
    if (flush_at < 0) begin
      check("rst_done_seen", 128'(done), 128'(1));
      check("rst_beats", 128'(i), 128'(NREGS * (deff - 1)));
      tick();
      check("rst_idle_after", 128'({xfer_done, xfer_busy}), 128'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    g_resetn = 1'b0; flush = 1'b0; smectl_d = 4'd3; rs1_addr = '0; rs2_addr = '0;
    rd_wen = 1'b0; rd_addr = '0; rd_wdata = '0; xfer_start = 1'b0; xfer_dir = 1'b0;
    so_ready = 1'b0; si_valid = 1'b0; si_data = '0;
`ifdef SME_SHARE_REFRESH_EN
    rng = '0; smectl_t = 1'b1;
`endif
    for (int r = 0; r < NREGS; r++) for (int k = 0; k < SMAX; k++) model[r][k] = '0;

    #12;
    rs1_addr = 4'd5;
    #1;
    check("reset_outs", 128'({xfer_busy, xfer_done, so_valid, si_ready}), 128'(0));
    check("reset_stream", 128'({so_data, so_reg, so_share}), 128'(0));
    check("reset_rs1", 128'(rs1_rdata), 128'(0));
    g_resetn = 1'b1;
    tick();

    // Write visible only after the edge.
    rd_addr = 4'd5; rd_wdata = {32'hC, 32'hB, 32'hA}; rd_wen = 1'b1;
    #1;
    check("no_bypass", 128'(rs1_rdata), 128'(0));
    tick();
    rd_wen = 1'b0;
    check("write_r5", 128'(rs1_rdata), 128'({32'hC, 32'hB, 32'hA}));

    for (int r = 0; r < NREGS; r++)
      write_reg(r, 32'hA000_0001 | (32'(r) << 8), 32'hA000_0002 | (32'(r) << 8), 32'hA000_0003 | (32'(r) << 8));
    verify_all("fill");
    tick();

    run_save(3, -1);
    run_save(3, 7);
    run_save(9, -1);
    verify_all("after_save");
    tick();

    run_restore(4, 32'h100, -1, 1'b0);
    verify_all("restore4");
    rs1_addr = 4'd7;
    #1;
    check("restore_r7", 128'(rs1_rdata), 128'({32'h117, 32'h116, 32'h115}));
    tick();

    run_restore(4, 32'h200, 10, 1'b0);
    verify_all("flush_nobeat");
    rs1_addr = 4'd3;
    #1;
    check("flush_r3", 128'(rs1_rdata), 128'({32'h10B, 32'h10A, 32'h209}));
    tick();

    run_restore(3, 32'h300, 5, 1'b1);
    verify_all("flush_commit");
    rs1_addr = 4'd2;
    #1;
    check("flush_commit_r2", 128'(rs1_rdata), 128'({32'h208, 32'h305, 32'h304}));
    tick();

    start_xfer(1, 1'b0);
    check("d1_done", 128'({xfer_done, xfer_busy, so_valid, si_ready}), 128'(4'b1100));
    tick();
    check("d1_idle", 128'({xfer_done, xfer_busy}), 128'(0));
    start_xfer(0, 1'b1);
    check("d0_done", 128'({xfer_done, xfer_busy, so_valid, si_ready}), 128'(4'b1100));
    tick();
    check("d0_idle", 128'({xfer_done, xfer_busy}), 128'(0));
    verify_all("after_d01");
    tick();

    // Reset in the middle of a save.
    so_ready = 1'b1;
    start_xfer(3, 1'b0);
    repeat (4) tick();
    #2;
    g_resetn = 1'b0;
    rs1_addr = 4'd5;
    #1;
    check("midreset_outs", 128'({xfer_busy, so_valid, xfer_done}), 128'(0));
    check("midreset_rs1", 128'(rs1_rdata), 128'(0));
    for (int r = 0; r < NREGS; r++) for (int k = 0; k < SMAX; k++) model[r][k] = '0;
    #3;
    g_resetn = 1'b1;
    tick();
    verify_all("midreset_all");
    tick();

`ifdef SME_SHARE_REFRESH_EN
    for (int r = 0; r < NREGS; r++)
      write_reg(r, 32'h1234_0000 + 32'(r), 32'h0000_5678 + 32'(r), 32'h0BAD_0000 + 32'(r));
    rng = 32'hFFFF_0000;
    smectl_d = 4'd3;
    smectl_t = 1'b0;
    repeat (16) tick();
    smectl_t = 1'b1;
    for (int r = 0; r < NREGS; r++) begin
      model[r][1] = model[r][1] ^ 32'hFFFF_0000;
      model[r][2] = model[r][2] ^ 32'hFFFF_0000;
    end
    verify_all("refresh");
    rs1_addr = 4'd4;
    #1;
    check("refresh_xor", 128'(rs1_rdata[31:0] ^ rs1_rdata[63:32]), 128'((32'h1234_0004 ^ 32'h0000_567C)));
    tick();
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
